bless_local_ni: RTL and testbench

//  Local network interface feeding the BLESS router's dinLocal port and draining its doutLocal port.

---
 rtl/bless_local_ni_pkg.sv | 42 ++++
 rtl/bless_local_ni_if.sv | 38 +++
 rtl/bless_local_ni_fifo.sv | 59 +++++
 rtl/bless_local_ni.sv | 149 ++++++++++++++
 tb/tb_bless_local_ni.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bless_local_ni_pkg.sv
// Shared field widths, bit positions and the flit layout for the BLESS local
// network interface. The flit is {pktId, flitId, stamp, xDst, yDst, payload}.
package bless_local_ni_pkg;

    localparam int WIDTH_PKT_ID  = 6;
    localparam int WIDTH_FLIT_ID = 4;
    localparam int WIDTH_TIME    = 8;
    localparam int WIDTH_X       = 3;
    localparam int WIDTH_Y       = 3;
    localparam int WIDTH_PLD     = 8;

    localparam int WIDTH_PORT = WIDTH_PKT_ID + WIDTH_FLIT_ID + WIDTH_TIME
                              + WIDTH_X + WIDTH_Y + WIDTH_PLD;

    localparam int POS_PLD     = 0;
    localparam int POS_Y_DST   = POS_PLD + WIDTH_PLD;
    localparam int POS_X_DST   = POS_Y_DST + WIDTH_Y;
    localparam int POS_TIME    = POS_X_DST + WIDTH_X;
    localparam int POS_FLIT_ID = POS_TIME + WIDTH_TIME;
    localparam int POS_PKT_ID  = POS_FLIT_ID + WIDTH_FLIT_ID;

    typedef struct packed {
        logic [WIDTH_PKT_ID-1:0]  pktId;
        logic [WIDTH_FLIT_ID-1:0] flitId;
        logic [WIDTH_TIME-1:0]    stamp;
        logic [WIDTH_X-1:0]       xDst;
        logic [WIDTH_Y-1:0]       yDst;
        logic [WIDTH_PLD-1:0]     payload;
    } flit_t;

    // Packet ids skip zero on wrap so a stamped flit can never look like "no flit".
    function automatic logic [WIDTH_PKT_ID-1:0] nextPktId(input logic [WIDTH_PKT_ID-1:0] id);
        logic [WIDTH_PKT_ID-1:0] one;
        one = {{(WIDTH_PKT_ID-1){1'b0}}, 1'b1};
        if (id == {WIDTH_PKT_ID{1'b1}}) begin
            return one;
        end else begin
            return id + one;
        end
    endfunction

endpackage

// File: rtl/bless_local_ni_if.sv
// PE-side, router-side and status signals of the local network interface.
interface bless_local_ni_if #(
    parameter int DROP_W = 16
);
    import bless_local_ni_pkg::*;

    logic                  inj_valid;
    logic                  inj_ready;
    logic                  inj_last;
    logic [WIDTH_X-1:0]    inj_xdst;
    logic [WIDTH_Y-1:0]    inj_ydst;
    logic [WIDTH_PLD-1:0]  inj_payload;
    logic [WIDTH_PORT-1:0] net_inW;
    logic [WIDTH_PORT-1:0] net_inE;
    logic [WIDTH_PORT-1:0] net_inS;
    logic [WIDTH_PORT-1:0] net_inN;
    logic [WIDTH_PORT-1:0] dinLocal;
    logic [WIDTH_PORT-1:0] doutLocal;
    logic                  ej_valid;
    logic                  ej_ready;
    logic [WIDTH_PORT-1:0] ej_flit;
    logic [WIDTH_TIME-1:0] ej_latency;
    logic                  ej_overflow;
    logic [DROP_W-1:0]     drop_count;

    modport slave (
        input  inj_valid, inj_last, inj_xdst, inj_ydst, inj_payload,
        input  net_inW, net_inE, net_inS, net_inN, doutLocal, ej_ready,
        output inj_ready, dinLocal, ej_valid, ej_flit, ej_latency, ej_overflow, drop_count
    );

    modport master (
        output inj_valid, inj_last, inj_xdst, inj_ydst, inj_payload,
        output net_inW, net_inE, net_inS, net_inN, doutLocal, ej_ready,
        input  inj_ready, dinLocal, ej_valid, ej_flit, ej_latency, ej_overflow, drop_count
    );

endinterface

// File: rtl/bless_local_ni_fifo.sv
// Synchronous FIFO with wrap-around pointers carrying an extra MSB to tell
// full from empty. A pop on empty is ignored; a push while full is accepted
// only when a pop frees the slot in the same cycle.
module ni_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wrPtr;
    logic [AW:0]      rdPtr;
    logic             doPush;
    logic             doPop;
    logic [AW:0]      ptrOne;

    // Status flags, qualified push/pop and the head view.
    always_comb begin
        ptrOne = {{AW{1'b0}}, 1'b1};
        empty  = (wrPtr == rdPtr);
        full   = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
        doPop  = pop & ~empty;
        doPush = push & (~full | doPop);
        head   = mem[rdPtr[AW-1:0]];
    end

    // Pointer advance; reset empties the FIFO.
    always_ff @(posedge clk) begin
        if (reset) begin
            wrPtr <= {(AW+1){1'b0}};
            rdPtr <= {(AW+1){1'b0}};
        end else begin
            if (doPush) begin
                wrPtr <= wrPtr + ptrOne;
            end
            if (doPop) begin
                rdPtr <= rdPtr + ptrOne;
            end
        end
    end

    // Data storage; contents need no reset because the pointers gate visibility.
    always_ff @(posedge clk) begin
        if (doPush) begin
            mem[wrPtr[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/bless_local_ni.sv
// Local network interface for a BLESS router: stamps and buffers PE flits for
// injection into free router slots, and buffers ejected flits for the PE while
// reporting their latency and counting any flit lost to a full buffer.
module bless_local_ni
    import bless_local_ni_pkg::*;
#(
    parameter int INJ_DEPTH = 4,
    parameter int EJ_DEPTH  = 8,
    parameter int DROP_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    bless_local_ni_if.slave   bus
);

    localparam logic [WIDTH_TIME-1:0]    TIME_ONE = {{(WIDTH_TIME-1){1'b0}}, 1'b1};
    localparam logic [WIDTH_FLIT_ID-1:0] FLIT_ONE = {{(WIDTH_FLIT_ID-1){1'b0}}, 1'b1};
    localparam logic [DROP_W-1:0]        DROP_ONE = {{(DROP_W-1){1'b0}}, 1'b1};

    logic [WIDTH_TIME-1:0]    cycleCtr;
    logic [WIDTH_PKT_ID-1:0]  pktId;
    logic [WIDTH_FLIT_ID-1:0] flitId;
    logic [WIDTH_TIME-1:0]    tsHold;
    logic                     inPacket;
    logic                     ejOverflow;
    logic [DROP_W-1:0]        dropCount;

    flit_t                    pushFlit;
    logic                     injReady;
    logic                     injPush;
    logic                     injGo;
    logic                     anyFree;
    logic                     injFull;
    logic                     injEmpty;
    logic [WIDTH_PORT-1:0]    injHead;

    logic                     ejArrive;
    logic                     ejPush;
    logic                     ejPop;
    logic                     ejDrop;
    logic                     ejFull;
    logic                     ejEmpty;
    logic [WIDTH_PORT-1:0]    ejHead;

    // Injection side: stamping, ready and the free-slot gate to the router.
    always_comb begin
        injReady = ~injFull & ~reset;
        injPush  = bus.inj_valid & injReady;
        anyFree  = (bus.net_inW == {WIDTH_PORT{1'b0}}) | (bus.net_inE == {WIDTH_PORT{1'b0}})
                 | (bus.net_inS == {WIDTH_PORT{1'b0}}) | (bus.net_inN == {WIDTH_PORT{1'b0}});
        injGo    = ~injEmpty & anyFree & ~reset;

        pushFlit         = '{default: 1'b0};
        pushFlit.pktId   = pktId;
        pushFlit.flitId  = flitId;
        pushFlit.stamp   = inPacket ? tsHold : cycleCtr;
        pushFlit.xDst    = bus.inj_xdst;
        pushFlit.yDst    = bus.inj_ydst;
        pushFlit.payload = bus.inj_payload;

        bus.inj_ready = injReady;
        if (injGo) begin
            bus.dinLocal = injHead;
        end else begin
            bus.dinLocal = {WIDTH_PORT{1'b0}};
        end
    end

    // Ejection side: capture never stalls the router, so a full buffer drops.
    always_comb begin
        ejArrive = (bus.doutLocal != {WIDTH_PORT{1'b0}}) & ~reset;
        ejPop    = ~ejEmpty & bus.ej_ready & ~reset;
        ejPush   = ejArrive & (~ejFull | ejPop);
        ejDrop   = ejArrive & ejFull & ~ejPop;

        bus.ej_valid    = ~ejEmpty & ~reset;
        bus.ej_flit     = ejHead;
        bus.ej_latency  = cycleCtr - ejHead[POS_TIME +: WIDTH_TIME];
        bus.ej_overflow = ejOverflow;
        bus.drop_count  = dropCount;
    end

    // Free-running timestamp counter; wraps silently.
    always_ff @(posedge clk) begin
        if (reset) begin
            cycleCtr <= {WIDTH_TIME{1'b0}};
        end else begin
            cycleCtr <= cycleCtr + TIME_ONE;
        end
    end

    // Packet/flit numbering and the timestamp held across a packet's flits.
    always_ff @(posedge clk) begin
        if (reset) begin
            pktId    <= {{(WIDTH_PKT_ID-1){1'b0}}, 1'b1};
            flitId   <= {WIDTH_FLIT_ID{1'b0}};
            tsHold   <= {WIDTH_TIME{1'b0}};
            inPacket <= 1'b0;
        end else if (injPush) begin
            if (bus.inj_last) begin
                flitId   <= {WIDTH_FLIT_ID{1'b0}};
                pktId    <= nextPktId(pktId);
                inPacket <= 1'b0;
            end else begin
                flitId   <= flitId + FLIT_ONE;
                inPacket <= 1'b1;
                if (!inPacket) begin
                    tsHold <= cycleCtr;
                end
            end
        end
    end

    // Sticky overflow flag and saturating drop counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            ejOverflow <= 1'b0;
            dropCount  <= {DROP_W{1'b0}};
        end else if (ejDrop) begin
            ejOverflow <= 1'b1;
            if (dropCount != {DROP_W{1'b1}}) begin
                dropCount <= dropCount + DROP_ONE;
            end
        end
    end

    ni_sync_fifo #(.WIDTH(WIDTH_PORT), .DEPTH(INJ_DEPTH)) injFifo (
        .clk   (clk),
        .reset (reset),
        .push  (injPush),
        .pop   (injGo),
        .din   (pushFlit),
        .full  (injFull),
        .empty (injEmpty),
        .head  (injHead)
    );

    ni_sync_fifo #(.WIDTH(WIDTH_PORT), .DEPTH(EJ_DEPTH)) ejFifo (
        .clk   (clk),
        .reset (reset),
        .push  (ejPush),
        .pop   (ejPop),
        .din   (bus.doutLocal),
        .full  (ejFull),
        .empty (ejEmpty),
        .head  (ejHead)
    );

endmodule

// File: tb/tb_bless_local_ni.sv
// Bench for bless_local_ni: directed sequences, a gate table and random traffic,
// all checked against a queue-based model of the interface.
module tb_bless_local_ni;
    import bless_local_ni_pkg::*;

    localparam int INJ_DEPTH = 4;
    localparam int EJ_DEPTH  = 8;
    localparam int DROP_W    = 16;
    localparam int PKT_MAX   = (1 << WIDTH_PKT_ID) - 1;
    localparam int TMOD      = 1 << WIDTH_TIME;
    localparam int FMOD      = 1 << WIDTH_FLIT_ID;
    localparam logic [WIDTH_PORT-1:0] BUSY = 32'h0000_0101;

    logic clk = 1'b0;
    logic reset = 1'b1;

    bless_local_ni_if #(.DROP_W(DROP_W)) bus();

    bless_local_ni #(.INJ_DEPTH(INJ_DEPTH), .EJ_DEPTH(EJ_DEPTH), .DROP_W(DROP_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    flit_t                 injQ[$];
    logic [WIDTH_PORT-1:0] ejQ[$];
    int                    mPkt, mFlit, mDrop, cyc, mTs;
    bit                    mMid, mOvf;
    logic [WIDTH_PORT-1:0] seenDin;

    typedef struct {
        logic [3:0] busy;   // {W,E,S,N} occupied
        logic       expGo;
    } gate_vec_t;

    gate_vec_t gateTab[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic setIdle();
        bus.inj_valid = 1'b0; bus.inj_last = 1'b0;
        bus.inj_xdst = '0; bus.inj_ydst = '0; bus.inj_payload = '0;
        bus.net_inW = '0; bus.net_inE = '0; bus.net_inS = '0; bus.net_inN = '0;
        bus.doutLocal = '0; bus.ej_ready = 1'b0;
    endtask

    task automatic setNets(input logic [3:0] busy);
        bus.net_inW = busy[3] ? BUSY : '0;
        bus.net_inE = busy[2] ? BUSY : '0;
        bus.net_inS = busy[1] ? BUSY : '0;
        bus.net_inN = busy[0] ? BUSY : '0;
    endtask

    function automatic int expLat(input logic [WIDTH_PORT-1:0] f);
        flit_t ff;
        ff = f;
        return ((cyc % TMOD) - int'(ff.stamp) + TMOD) % TMOD;
    endfunction

    // Check all outputs against the model, then advance one clock and the model.
    task automatic stepCheck();
        bit                    go, ejPop, arrive, accept, lastIn;
        logic [WIDTH_PORT-1:0] expDin, dout;
        flit_t                 nf;
        #1;
        go = (injQ.size() > 0) && (bus.net_inW == '0 || bus.net_inE == '0 ||
                                   bus.net_inS == '0 || bus.net_inN == '0);
        expDin = '0;
        if (go) expDin = injQ[0];
        chk("inj_ready", bus.inj_ready, injQ.size() < INJ_DEPTH);
        chk("dinLocal", bus.dinLocal, expDin);
        seenDin = bus.dinLocal;
        chk("ej_valid", bus.ej_valid, ejQ.size() > 0);
        if (ejQ.size() > 0) begin
            chk("ej_flit", bus.ej_flit, ejQ[0]);
            chk("ej_latency", bus.ej_latency, expLat(ejQ[0]));
        end
        chk("ej_overflow", bus.ej_overflow, mOvf);
        chk("drop_count", bus.drop_count, mDrop);

        ejPop  = (ejQ.size() > 0) && bus.ej_ready;
        arrive = (bus.doutLocal != '0);
        dout   = bus.doutLocal;
        accept = bus.inj_valid && (injQ.size() < INJ_DEPTH);
        lastIn = bus.inj_last;
        nf.pktId   = WIDTH_PKT_ID'(mPkt);
        nf.flitId  = WIDTH_FLIT_ID'(mFlit);
        nf.stamp   = WIDTH_TIME'(mMid ? mTs : cyc % TMOD);
        nf.xDst    = bus.inj_xdst;
        nf.yDst    = bus.inj_ydst;
        nf.payload = bus.inj_payload;

        @(posedge clk);
        if (go) void'(injQ.pop_front());
        if (accept) begin
            injQ.push_back(nf);
            if (lastIn) begin
                mFlit = 0;
                mPkt  = (mPkt == PKT_MAX) ? 1 : mPkt + 1;
                mMid  = 1'b0;
            end else begin
                if (!mMid) mTs = cyc % TMOD;
                mMid  = 1'b1;
                mFlit = (mFlit + 1) % FMOD;
            end
        end
        if (ejPop) void'(ejQ.pop_front());
        if (arrive) begin
            if (ejQ.size() < EJ_DEPTH) begin
                ejQ.push_back(dout);
            end else begin
                mOvf = 1'b1;
                if (mDrop < (1 << DROP_W) - 1) mDrop++;
            end
        end
        cyc++;
        #2;
    endtask

    task automatic doReset();
        setIdle();
        reset = 1'b1;
        bus.inj_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("rst_inj_ready", bus.inj_ready, 1'b0);
            chk("rst_dinLocal", bus.dinLocal, '0);
            @(posedge clk);
            #2;
        end
        reset = 1'b0;
        bus.inj_valid = 1'b0;
        injQ.delete(); ejQ.delete();
        mPkt = 1; mFlit = 0; mMid = 1'b0; mTs = 0; cyc = 0; mOvf = 1'b0; mDrop = 0;
    endtask

    initial begin
        flit_t seenF;
        flit_t f6;
        int    t0;

        gateTab[0] = '{4'hF, 1'b0};
        gateTab[1] = '{4'h0, 1'b1};
        gateTab[2] = '{4'h7, 1'b1};
        gateTab[3] = '{4'hB, 1'b1};
        gateTab[4] = '{4'hD, 1'b1};
        gateTab[5] = '{4'hE, 1'b1};
        gateTab[6] = '{4'hF, 1'b0};
        gateTab[7] = '{4'h5, 1'b1};

        // Reset with a flit offered.
        doReset();
        stepCheck();
        chk("post_rst_drop", bus.drop_count, 0);

        // Three-flit packet through an open router, then a second packet.
        t0 = cyc;
        for (int k = 0; k < 4; k++) begin
            bus.inj_valid   = (k < 3);
            bus.inj_last    = (k == 2);
            bus.inj_payload = 8'hA0 + 8'(k);
            stepCheck();
            if (k >= 1) begin
                seenF = seenDin;
                chk("t2_flit_id", seenF.flitId, k - 1);
                chk("t2_pkt_id", seenF.pktId, 1);
                chk("t2_ts", seenF.stamp, t0 % TMOD);
            end
        end
        bus.inj_valid = 1'b1; bus.inj_last = 1'b1; bus.inj_payload = 8'hB0;
        stepCheck();
        setIdle();
        stepCheck();
        seenF = seenDin;
        chk("t2_next_pkt", seenF.pktId, 2);

        // Router fully occupied: flits wait, then a free N slot releases one.
        setNets(4'hF);
        bus.inj_valid = 1'b1; bus.inj_last = 1'b0; bus.inj_payload = 8'hC1;
        stepCheck();
        bus.inj_last = 1'b1; bus.inj_payload = 8'hC2;
        stepCheck();
        bus.inj_valid = 1'b0; bus.inj_last = 1'b0;
        for (int k = 0; k < 5; k++) begin
            stepCheck();
            chk("t3_blocked", seenDin, '0);
            chk("t3_ready", bus.inj_ready, 1'b1);
        end
        setNets(4'hE);
        stepCheck();
        seenF = seenDin;
        chk("t3_inject_pld", seenF.payload, 8'hC1);
        setNets(4'h0);
        stepCheck();
        stepCheck();

        // Fill the injection FIFO, then pop while full and pop+push at 3.
        setNets(4'hF);
        bus.inj_last = 1'b1;
        for (int k = 0; k < 4; k++) begin
            bus.inj_valid = 1'b1; bus.inj_payload = 8'hD0 + 8'(k);
            stepCheck();
        end
        chk("t4_full_ready", bus.inj_ready, 1'b0);
        bus.inj_payload = 8'hD4;
        setNets(4'h0);
        stepCheck();
        chk("t4_after_pop_ready", bus.inj_ready, 1'b1);
        bus.inj_payload = 8'hD5;
        stepCheck();
        setNets(4'hF);
        bus.inj_payload = 8'hD6;
        stepCheck();
        chk("t4_refull_ready", bus.inj_ready, 1'b0);
        bus.inj_valid = 1'b0;
        setNets(4'h0);
        for (int k = 0; k < 5; k++) stepCheck();

        // Ejection overflow, then full buffer with pop and arrival together.
        setIdle();
        for (int k = 0; k < 9; k++) begin
            bus.doutLocal = WIDTH_PORT'($urandom()) | 32'h1;
            stepCheck();
        end
        bus.doutLocal = '0;
        stepCheck();
        chk("t5_overflow", bus.ej_overflow, 1'b1);
        chk("t5_drop", bus.drop_count, 1);
        bus.ej_ready = 1'b1;
        bus.doutLocal = 32'h0000_0777;
        stepCheck();
        bus.ej_ready = 1'b0; bus.doutLocal = '0;
        stepCheck();
        chk("t5_no_extra_drop", bus.drop_count, 1);
        bus.ej_ready = 1'b1;
        for (int k = 0; k < 9; k++) stepCheck();
        chk("t5_drained", bus.ej_valid, 1'b0);

        // Gate table: each entry offers one queued flit to a given occupancy.
        for (int i = 0; i < 8; i++) begin
            setIdle();
            setNets(4'hF);
            bus.inj_valid = 1'b1; bus.inj_last = 1'b1; bus.inj_payload = 8'(8'h40 + i);
            stepCheck();
            bus.inj_valid = 1'b0;
            setNets(gateTab[i].busy);
            stepCheck();
            chk("gate_tab", (seenDin != '0), gateTab[i].expGo);
            setNets(4'h0);
            stepCheck();
        end

        // Latency wrap and pkt_id wrap from a fresh reset.
        doReset();
        f6 = '0;
        f6.stamp = WIDTH_TIME'(TMOD - 2);
        f6.payload = 8'h5A;
        bus.doutLocal = f6;
        stepCheck();
        bus.doutLocal = '0;
        stepCheck();
        stepCheck();
        #1;
        chk("t6_latency_wrap", bus.ej_latency, 5);
        bus.ej_ready = 1'b1;
        stepCheck();
        bus.ej_ready = 1'b0;
        bus.inj_valid = 1'b1; bus.inj_last = 1'b1;
        for (int k = 0; k <= PKT_MAX + 1; k++) begin
            bus.inj_payload = 8'(k);
            stepCheck();
            seenF = seenDin;
            if (k == PKT_MAX) chk("t6_pkt_max", seenF.pktId, PKT_MAX);
            if (k == PKT_MAX + 1) chk("t6_pkt_wrap", seenF.pktId, 1);
        end
        setIdle();
        stepCheck();

        // Random traffic against the model.
        for (int k = 0; k < 400; k++) begin
            bus.inj_valid   = ($urandom_range(0, 99) < 60);
            bus.inj_last    = ($urandom_range(0, 99) < 35);
            bus.inj_xdst    = WIDTH_X'($urandom());
            bus.inj_ydst    = WIDTH_Y'($urandom());
            bus.inj_payload = WIDTH_PLD'($urandom());
            setNets({($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
                     ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)});
            bus.doutLocal   = ($urandom_range(0, 99) < 60) ? (WIDTH_PORT'($urandom()) | 32'h1) : '0;
            bus.ej_ready    = ($urandom_range(0, 99) < 50);
            stepCheck();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
